// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W = 64;

    // Access size encodings on req_size
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    // Number of bytes moved by an access of the given size
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Address bits below the access size (must be zero when aligned)
    function automatic logic [2:0] low_mask(input logic [1:0] size);
        return 3'(size_bytes(size) - 4'd1);
    endfunction

endpackage

// File: rtl/data_mem_lsu_lane_align.sv
// lsu_lane_align: byte-lane extraction/extension for loads and lane merge for stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rbuf,
    input  logic [2:0]        off,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_data
);

    logic [5:0]        shamt;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;

    // Shift the addressed lane down, extend it, and splice store data into the doubleword
    always_comb begin
        shamt     = {off, 3'b000};
        lane      = rbuf >> shamt;
        mask      = (size == SZ_D) ? '1
                  : ((DATA_W'(1) << {size_bytes(size), 3'b000}) - DATA_W'(1));
        load_data = lane;
        case (size)
            SZ_B:    load_data = uns ? DATA_W'(lane[7:0])  : {{56{lane[7]}},  lane[7:0]};
            SZ_H:    load_data = uns ? DATA_W'(lane[15:0]) : {{48{lane[15]}}, lane[15:0]};
            SZ_W:    load_data = uns ? DATA_W'(lane[31:0]) : {{32{lane[31]}}, lane[31:0]};
            default: load_data = lane;
        endcase
        store_data = (rbuf & ~(mask << shamt)) | ((wdata & mask) << shamt);
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-outstanding load/store unit driving a doubleword data RAM.
// Sub-doubleword stores are done as read-modify-write.
// Optional macro MISALIGN_CHECK_EN: reject misaligned accesses instead of masking low bits.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    localparam int unsigned ADDR_BITS = $clog2(DEPTH * 8);
    localparam int unsigned CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              l_write, l_write_n;
    logic [1:0]        l_size, l_size_n;
    logic              l_uns, l_uns_n;
    logic [2:0]        l_off, l_off_n;
    logic [DATA_W-1:0] l_wdata, l_wdata_n;
    logic              mem_read_n, mem_write_n, rsp_valid_n, rsp_err_n;
    logic [DATA_W-1:0] mem_addr_n, write_data_n, rsp_rdata_n;
    logic              oor_c, misalign_c;
    logic [2:0]        off_c;
    logic [DATA_W-1:0] load_data_c, store_data_c;

    assign req_ready = reset && (state == IDLE);

    // Request qualification: range check, alignment handling, lane offset
    always_comb begin
        oor_c = (req_addr >> ADDR_BITS) != '0;
        off_c = req_addr[2:0] & ~low_mask(req_size);
`ifdef MISALIGN_CHECK_EN
        misalign_c = (req_addr[2:0] & low_mask(req_size)) != 3'b000;
`else
        misalign_c = 1'b0;
`endif
    end

    lsu_lane_align u_align (
        .rbuf       (read_data),
        .off        (l_off),
        .size       (l_size),
        .uns        (l_uns),
        .wdata      (l_wdata),
        .load_data  (load_data_c),
        .store_data (store_data_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        l_write_n    = l_write;
        l_size_n     = l_size;
        l_uns_n      = l_uns;
        l_off_n      = l_off;
        l_wdata_n    = l_wdata;
        mem_addr_n   = mem_addr;
        write_data_n = write_data;
        rsp_rdata_n  = rsp_rdata;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        rsp_valid_n  = 1'b0;
        rsp_err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    l_write_n = req_write;
                    l_size_n  = req_size;
                    l_uns_n   = req_unsigned;
                    l_off_n   = off_c;
                    l_wdata_n = req_wdata;
                    if (oor_c || misalign_c) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                    end else begin
                        mem_addr_n = {3'b000, req_addr[DATA_W-1:3]};
                        if (req_write && (req_size == SZ_D)) begin
                            state_n      = WR;
                            mem_write_n  = 1'b1;
                            write_data_n = req_wdata;
                        end else begin
                            state_n    = RD;
                            mem_read_n = 1'b1;
                            cnt_n      = '0;
                        end
                    end
                end
            end
            RD: begin
                if (cnt == CNT_LAST) begin
                    if (l_write) begin
                        state_n      = WR;
                        mem_write_n  = 1'b1;
                        write_data_n = store_data_c;
                    end else begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_rdata_n = load_data_c;
                    end
                end else begin
                    cnt_n      = cnt + CNT_W'(1);
                    mem_read_n = 1'b1;
                end
            end
            WR: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = '0;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset drops strobes immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            l_write    <= 1'b0;
            l_size     <= SZ_B;
            l_uns      <= 1'b0;
            l_off      <= '0;
            l_wdata    <= '0;
            mem_addr   <= '0;
            write_data <= '0;
            rsp_rdata  <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            l_write    <= l_write_n;
            l_size     <= l_size_n;
            l_uns      <= l_uns_n;
            l_off      <= l_off_n;
            l_wdata    <= l_wdata_n;
            mem_addr   <= mem_addr_n;
            write_data <= write_data_n;
            rsp_rdata  <= rsp_rdata_n;
            MemRead    <= mem_read_n;
            MemWrite   <= mem_write_n;
            rsp_valid  <= rsp_valid_n;
            rsp_err    <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu with a behavioural doubleword RAM.
module tb_data_mem_lsu;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned RD_LAT = 1;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, D = 2'b11;

    logic        clk, reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, MemRead, MemWrite;
    logic [63:0] rsp_rdata, mem_addr, write_data, read_data;
    logic [63:0] ram [DEPTH];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        err;
        logic [63:0] rdata;
        int          lat;
        int          rd;
        int          wr;
        logic [63:0] maddr;
        logic [63:0] wd;
    } vec_t;

    vec_t vq[$];

    data_mem_lsu #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = MemRead ? ram[mem_addr[4:0]] : 64'h0;

    always @(posedge clk) begin
        if (MemWrite) ram[mem_addr[4:0]] <= write_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic err, input logic [63:0] rdata, input int lat,
                                input int rd, input int wr, input logic [63:0] maddr,
                                input logic [63:0] wd);
        vec_t v;
        v.w = w; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.lat = lat; v.rd = rd; v.wr = wr;
        v.maddr = maddr; v.wd = wd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int rd_n = 0, wr_n = 0, both = 0, lat = 0;
        logic [63:0] rd_addr = '0, wr_addr = '0, wd = '0, rdata = '0;
        logic err = 1'b0, busy_ready = 1'b1;
        chk($sformatf("v%0d ready_idle", idx), 64'(req_ready), 64'(1));
        req_write = v.w; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) busy_ready = req_ready;
            if (MemRead)  begin rd_n++; rd_addr = mem_addr; end
            if (MemWrite) begin wr_n++; wr_addr = mem_addr; wd = write_data; end
            if (MemRead && MemWrite) both++;
            if (rsp_valid) begin lat = c; rdata = rsp_rdata; err = rsp_err; break; end
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d rsp_err", idx), 64'(err), 64'(v.err));
        chk($sformatf("v%0d rsp_rdata", idx), rdata, v.rdata);
        chk($sformatf("v%0d read_cycles", idx), 64'(rd_n), 64'(v.rd));
        chk($sformatf("v%0d write_cycles", idx), 64'(wr_n), 64'(v.wr));
        chk($sformatf("v%0d strobe_overlap", idx), 64'(both), 64'(0));
        chk($sformatf("v%0d busy_not_ready", idx), 64'(busy_ready), 64'(0));
        if (v.rd > 0) chk($sformatf("v%0d rd_mem_addr", idx), rd_addr, v.maddr);
        if (v.wr > 0) begin
            chk($sformatf("v%0d wr_mem_addr", idx), wr_addr, v.maddr);
            chk($sformatf("v%0d write_data", idx), wd, v.wd);
        end
        @(negedge clk);
        chk($sformatf("v%0d rsp_pulse", idx), 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = B;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Vector table: load latency RD_LAT+1, RMW RD_LAT+2, double store 2, error 1
        vq.push_back(mk(1, D, 0, 64'h10, 64'h8000,                0, 64'h0, 2, 0, 1, 64'd2, 64'h8000));
        vq.push_back(mk(0, B, 0, 64'h11, 64'h0,                   0, 64'hFFFF_FFFF_FFFF_FF80, 2, 1, 0, 64'd2, 64'h0));
        vq.push_back(mk(0, B, 1, 64'h11, 64'h0,                   0, 64'h80, 2, 1, 0, 64'd2, 64'h0));
        vq.push_back(mk(1, D, 0, 64'h08, 64'h1122_3344_5566_7788, 0, 64'h0, 2, 0, 1, 64'd1, 64'h1122_3344_5566_7788));
        vq.push_back(mk(1, H, 0, 64'h0A, 64'hFFFF_FFFF_FFFF_ABCD, 0, 64'h0, 3, 1, 1, 64'd1, 64'h1122_3344_ABCD_7788));
        vq.push_back(mk(0, D, 0, 64'h08, 64'h0,                   0, 64'h1122_3344_ABCD_7788, 2, 1, 0, 64'd1, 64'h0));
        vq.push_back(mk(0, W, 0, 64'h0C, 64'h0,                   0, 64'h0000_0000_1122_3344, 2, 1, 0, 64'd1, 64'h0));
        vq.push_back(mk(0, H, 0, 64'h0A, 64'h0,                   0, 64'hFFFF_FFFF_FFFF_ABCD, 2, 1, 0, 64'd1, 64'h0));
        vq.push_back(mk(1, B, 0, 64'h0F, 64'h5A,                  0, 64'h0, 3, 1, 1, 64'd1, 64'h5A22_3344_ABCD_7788));
        vq.push_back(mk(1, D, 0, 64'h18, 64'hDEAD_BEEF_0000_0001, 0, 64'h0, 2, 0, 1, 64'd3, 64'hDEAD_BEEF_0000_0001));
        vq.push_back(mk(0, W, 0, 64'h1C, 64'h0,                   0, 64'hFFFF_FFFF_DEAD_BEEF, 2, 1, 0, 64'd3, 64'h0));
        vq.push_back(mk(0, W, 1, 64'h1C, 64'h0,                   0, 64'h0000_0000_DEAD_BEEF, 2, 1, 0, 64'd3, 64'h0));
        vq.push_back(mk(0, B, 0, 64'h100, 64'h0,                  1, 64'h0, 1, 0, 0, 64'd0, 64'h0));
        vq.push_back(mk(1, D, 0, 64'h100, 64'h1234,               1, 64'h0, 1, 0, 0, 64'd0, 64'h0));
        vq.push_back(mk(0, D, 0, 64'h8000_0000_0000_0008, 64'h0,  1, 64'h0, 1, 0, 0, 64'd0, 64'h0));
        vq.push_back(mk(1, D, 0, 64'hF8, 64'h7F00_0000_0000_0000, 0, 64'h0, 2, 0, 1, 64'd31, 64'h7F00_0000_0000_0000));
        vq.push_back(mk(0, B, 0, 64'hFF, 64'h0,                   0, 64'h7F, 2, 1, 0, 64'd31, 64'h0));
        vq.push_back(mk(1, D, 0, 64'h00, 64'h8877_6655_4433_2211, 0, 64'h0, 2, 0, 1, 64'd0, 64'h8877_6655_4433_2211));
`ifdef MISALIGN_CHECK_EN
        vq.push_back(mk(0, W, 0, 64'h06, 64'h0,                   1, 64'h0, 1, 0, 0, 64'd0, 64'h0));
        vq.push_back(mk(0, H, 0, 64'h03, 64'h0,                   1, 64'h0, 1, 0, 0, 64'd0, 64'h0));
        vq.push_back(mk(1, W, 0, 64'h05, 64'h0102_0304,           1, 64'h0, 1, 0, 0, 64'd0, 64'h0));
        vq.push_back(mk(0, D, 0, 64'h00, 64'h0,                   0, 64'h8877_6655_4433_2211, 2, 1, 0, 64'd0, 64'h0));
        vq.push_back(mk(0, D, 0, 64'h01, 64'h0,                   1, 64'h0, 1, 0, 0, 64'd0, 64'h0));
`else
        vq.push_back(mk(0, W, 0, 64'h06, 64'h0,                   0, 64'hFFFF_FFFF_8877_6655, 2, 1, 0, 64'd0, 64'h0));
        vq.push_back(mk(0, H, 0, 64'h03, 64'h0,                   0, 64'h0000_0000_0000_4433, 2, 1, 0, 64'd0, 64'h0));
        vq.push_back(mk(1, W, 0, 64'h05, 64'h0102_0304,           0, 64'h0, 3, 1, 1, 64'd0, 64'h0102_0304_4433_2211));
        vq.push_back(mk(0, D, 0, 64'h00, 64'h0,                   0, 64'h0102_0304_4433_2211, 2, 1, 0, 64'd0, 64'h0));
        vq.push_back(mk(0, D, 0, 64'h01, 64'h0,                   0, 64'h0102_0304_4433_2211, 2, 1, 0, 64'd0, 64'h0));
`endif

        // Reset state
        #12;
        chk("rst MemRead", 64'(MemRead), 64'(0));
        chk("rst MemWrite", 64'(MemWrite), 64'(0));
        chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst rsp_err", 64'(rsp_err), 64'(0));
        chk("rst mem_addr", mem_addr, 64'h0);
        chk("rst write_data", write_data, 64'h0);
        chk("rst rsp_rdata", rsp_rdata, 64'h0);
        chk("rst req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

        // Reset pulled low during RD aborts the load without a response
        req_write = 1'b0; req_size = B; req_unsigned = 1'b1; req_addr = 64'h11; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("midrd MemRead_on", 64'(MemRead), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("midrd MemRead_async_drop", 64'(MemRead), 64'(0));
        chk("midrd ready_in_reset", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("midrd no_rsp", 64'(rsp_valid), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("midrd ready_after_release", 64'(req_ready), 64'(1));
        chk("midrd no_rsp_after", 64'(rsp_valid), 64'(0));
        chk("midrd no_read_after", 64'(MemRead), 64'(0));

        // Normal operation resumes after the aborted load
        run_vec(mk(0, B, 1, 64'h11, 64'h0, 0, 64'h80, 2, 1, 0, 64'd2, 64'h0), 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
